calc_engine: RTL

CALC_ENGINE -- requirements
Module: calc_engine

---
 rtl/calc_engine_if.sv | 27 ++
 rtl/calc_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_engine_if.sv
// calc_engine_if -- request/response bundle for the calculator engine.
//   master : drives digit_inc, clear_entry, next_op, op_sel; observes results
//   slave  : the engine; drives seg, step, busy, negative, overflow
// seg packs one active-low gfedcba glyph per digit, digit i at [7i+6:7i].
interface calc_engine_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0]   digit_inc;
  logic                    clear_entry;
  logic                    next_op;
  logic [1:0]              op_sel;
  logic [7*NUM_DIGITS-1:0] seg;
  logic [1:0]              step;
  logic                    busy;
  logic                    negative;
  logic                    overflow;

  modport master (
    output digit_inc, clear_entry, next_op, op_sel,
    input  seg, step, busy, negative, overflow
  );

  modport slave (
    input  digit_inc, clear_entry, next_op, op_sel,
    output seg, step, busy, negative, overflow
  );
endinterface

// File: rtl/calc_engine.sv
// calc_engine -- BCD-entry four-function calculator.
//   Operands are keyed in as BCD digits, combined into a binary value,
//   operated on in one cycle, saturated to NUM_DIGITS decimal digits and
//   converted back to BCD with a shift-add-3 loop (one bit per cycle).
// Ports:
//   clk    : system clock, all state on posedge
//   reset  : synchronous active-high reset
//   cif    : calc_engine_if.slave (entry pulses, op select, display/status)
// Build option:
//   CALC_DIV_EN : when defined op_sel=3 divides; otherwise op_sel=3 gives
//                 result 0 with overflow and no divider is built.

// Per-digit 7-segment decoder, active-low gfedcba.
module calc_seg_dec (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module calc_engine #(
  parameter int NUM_DIGITS = 4
) (
  input logic          clk,
  input logic          reset,
  calc_engine_if.slave cif
);
  localparam int OP_W = 2;
  localparam int EW   = 4*NUM_DIGITS;          // entry / result width
  localparam int RW   = 2*EW;                  // full-width raw result
  localparam int CW   = $clog2(EW+1);
  localparam logic [RW-1:0] MAXV = RW'(10**NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    S_ENTER_A, S_ENTER_B, S_COMPUTE, S_CONVERT, S_SHOW
  } state_t;

  state_t st_q, st_nxt;

  logic [NUM_DIGITS-1:0][3:0] digit_q;
  logic [EW-1:0]              opa_q, opb_q, res_q;
  logic [OP_W-1:0]            op_q;
  logic [EW-1:0]              bcd_q, bin_q;
  logic [CW-1:0]              cnt_q;
  logic                       neg_q, ovf_q;

  logic [EW-1:0]              entry_val;
  logic [RW-1:0]              raw;
  logic [EW-1:0]              res_c;
  logic                       neg_c, ovf_c;
  logic [EW-1:0]              adj, bcd_nxt;
  logic                       adv;
  logic                       conv_last;

  // clear_entry wins over next_op when both pulse together.
  assign adv       = cif.next_op & ~cif.clear_entry;
  assign conv_last = (cnt_q == CW'(EW-1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) st_q <= S_ENTER_A;
    else       st_q <= st_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    st_nxt = st_q;
    case (st_q)
      S_ENTER_A: if (adv) st_nxt = S_ENTER_B;
      S_ENTER_B: if (adv) st_nxt = S_COMPUTE;
      S_COMPUTE: st_nxt = S_CONVERT;
      S_CONVERT: if (conv_last) st_nxt = S_SHOW;
      S_SHOW:    if (adv) st_nxt = S_ENTER_B;
      default:   st_nxt = S_ENTER_A;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cif.step = 2'd0;
    cif.busy = 1'b0;
    case (st_q)
      S_ENTER_B: cif.step = 2'd1;
      S_COMPUTE,
      S_CONVERT: begin
        cif.step = 2'd2;
        cif.busy = 1'b1;
      end
      S_SHOW:    cif.step = 2'd3;
      default:   cif.step = 2'd0;
    endcase
  end

  assign cif.negative = neg_q;
  assign cif.overflow = ovf_q;

  // Binary value of the keyed-in digits.
  always_comb begin
    entry_val = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      entry_val = entry_val + EW'(digit_q[i]) * EW'(10**i);
  end

  // Single-cycle ALU with saturation to the displayable range.
  always_comb begin
    raw   = '0;
    neg_c = 1'b0;
    ovf_c = 1'b0;
    case (op_q)
      2'd0: raw = RW'(opa_q) + RW'(opb_q);
      2'd1: begin
        // Show magnitude and flag the sign instead of wrapping.
        if (opb_q > opa_q) begin
          raw   = RW'(opb_q - opa_q);
          neg_c = 1'b1;
        end else begin
          raw   = RW'(opa_q - opb_q);
        end
      end
      2'd2: raw = RW'(opa_q) * RW'(opb_q);
      default: begin
`ifdef CALC_DIV_EN
        if (opb_q == '0) ovf_c = 1'b1;
        else             raw   = RW'(opa_q / opb_q);
`else
        ovf_c = 1'b1;
`endif
      end
    endcase
    if (raw > MAXV) begin
      ovf_c = 1'b1;
      res_c = EW'(MAXV);
    end else begin
      res_c = raw[EW-1:0];
    end
  end

  // Shift-add-3: bias any BCD digit >= 5 before the left shift so the
  // doubling carries correctly into the next decimal digit.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    bcd_nxt = {adj[EW-2:0], bin_q[EW-1]};
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (st_q)
        S_ENTER_A, S_ENTER_B: begin
          if (cif.clear_entry) begin
            digit_q <= '0;
          end else if (cif.next_op) begin
            // Latch the pre-increment value; same-cycle digit_inc is dropped.
            if (st_q == S_ENTER_A) begin
              opa_q   <= entry_val;
              digit_q <= '0;
            end else begin
              opb_q   <= entry_val;
              op_q    <= cif.op_sel;
            end
          end else begin
            for (int i = 0; i < NUM_DIGITS; i++)
              if (cif.digit_inc[i])
                digit_q[i] <= (digit_q[i] == 4'd9) ? 4'd0 : digit_q[i] + 4'd1;
          end
        end
        S_COMPUTE: begin
          res_q <= res_c;
          bin_q <= res_c;
          bcd_q <= '0;
          cnt_q <= '0;
          neg_q <= neg_c;
          ovf_q <= ovf_c;
        end
        S_CONVERT: begin
          bcd_q <= bcd_nxt;
          bin_q <= {bin_q[EW-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
          if (conv_last) digit_q <= bcd_nxt;
        end
        S_SHOW: begin
          if (cif.clear_entry) begin
            digit_q <= '0;
          end else if (cif.next_op) begin
            // Chain: the saturated magnitude becomes the next operand A.
            opa_q   <= res_q;
            digit_q <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- display ----------------
  logic [NUM_DIGITS-1:0][6:0] seg_w;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    calc_seg_dec u_dec (
      .bcd (digit_q[g]),
      .seg (seg_w[g])
    );
  end

  assign cif.seg = seg_w;
endmodule
